register_select_encoder: RTL and testbench

Sequential encoder that converts a 32-bit register-select mask back into 5-bit register indices, one per handshake, lowest index first. It sits beside the register file on the debug/context-save path and turns a multi-hot mask of registers into a stream of read addresses for the register file read port. It is the inverse of the register-file write-select decoder: a one-hot mask `32'h0000_0001 << k` yields exactly index `k`.

---
 rtl/register_select_encoder.sv | 87 ++++++++
 tb/tb_register_select_encoder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/register_select_encoder.sv
// Streams the set bits of a 32-bit register-select mask out as 5-bit indices,
// lowest first, one per valid/ready handshake. Inverse of the write-select decoder.
module register_select_encoder #(
  parameter int SKIP_ZERO = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start_i,
  input  logic [31:0] Select_Register_i,
  input  logic        Ready_i,
  output logic        Valid_o,
  output logic [4:0]  Register_Index_o,
  output logic        Busy_o,
  output logic        Done_o,
  output logic [5:0]  Count_o
);

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pending, w_pending_nxt;
  logic [5:0]  r_count, w_count_nxt;

  logic [31:0] w_load_mask;
  logic [31:0] w_pending_clr;
  logic [4:0]  w_low_idx;

  // x0 is hardwired, so it is optionally stripped before it can ever be emitted
  assign w_load_mask   = (SKIP_ZERO != 0) ? {Select_Register_i[31:1], 1'b0} : Select_Register_i;
  assign w_pending_clr = r_pending & (r_pending - 32'd1);

  always_comb begin
    w_low_idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (r_pending[i]) w_low_idx = 5'(i);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_pending <= '0;
      r_count   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_count   <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    w_count_nxt   = r_count;
    Valid_o       = 1'b0;
    Busy_o        = 1'b0;
    Done_o        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Start_i) begin
          w_pending_nxt = w_load_mask;
          w_count_nxt   = '0;
          w_state_nxt   = (w_load_mask == '0) ? S_DONE : S_EMIT;
        end
      end
      S_EMIT: begin
        Valid_o = 1'b1;
        Busy_o  = 1'b1;
        if (Ready_i) begin
          w_pending_nxt = w_pending_clr;
          w_count_nxt   = r_count + 6'd1;
          if (w_pending_clr == '0) w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        Busy_o      = 1'b1;
        Done_o      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign Register_Index_o = Valid_o ? w_low_idx : 5'd0;
  assign Count_o          = r_count;

endmodule

// File: tb/tb_register_select_encoder.sv
// Bench for register_select_encoder: two instances (SKIP_ZERO=1 as A, 0 as B) share
// stimulus and are compared each cycle against a queue-of-indices reference model.
module tb_register_select_encoder;

  logic        clk = 1'b0;
  logic        reset, start, ready;
  logic [31:0] mask;
  logic        vld[2];
  logic [4:0]  idx[2];
  logic        bsy[2], dn[2];
  logic [5:0]  cnt[2];

  always #5 clk = ~clk;

  register_select_encoder #(.SKIP_ZERO(1)) dut_a (
    .clk(clk), .reset(reset), .Start_i(start), .Select_Register_i(mask), .Ready_i(ready),
    .Valid_o(vld[0]), .Register_Index_o(idx[0]), .Busy_o(bsy[0]), .Done_o(dn[0]), .Count_o(cnt[0]));

  register_select_encoder #(.SKIP_ZERO(0)) dut_b (
    .clk(clk), .reset(reset), .Start_i(start), .Select_Register_i(mask), .Ready_i(ready),
    .Valid_o(vld[1]), .Register_Index_o(idx[1]), .Busy_o(bsy[1]), .Done_o(dn[1]), .Count_o(cnt[1]));

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the list of indices still owed, the accepted count, and a done flag
  int mq[2][$];
  int mcnt[2];
  bit mdone[2];
  int cap[$];

  typedef struct {
    logic [31:0] m;
    int          cnt_a;
    int          cnt_b;
    int          first_a;
  } vec_t;

  function automatic bit mbusy(int s);
    return (mq[s].size() > 0) || mdone[s];
  endfunction

  task automatic chk(string nm, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      mq[s].delete();
      mcnt[s]  = 0;
      mdone[s] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int s = 0; s < 2; s++) begin
      if (mdone[s]) mdone[s] = 1'b0;
      else if (mq[s].size() > 0) begin
        if (ready) begin
          void'(mq[s].pop_front());
          mcnt[s]++;
          if (mq[s].size() == 0) mdone[s] = 1'b1;
        end
      end else if (start) begin
        mcnt[s] = 0;
        for (int k = (s == 0) ? 1 : 0; k < 32; k++)
          if (mask[k]) mq[s].push_back(k);
        if (mq[s].size() == 0) mdone[s] = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    for (int s = 0; s < 2; s++) begin
      string p;
      bit ev;
      p  = (s == 0) ? "A" : "B";
      ev = mq[s].size() > 0;
      chk({p, ".valid"}, int'(vld[s]), int'(ev));
      chk({p, ".index"}, int'(idx[s]), ev ? mq[s][0] : 0);
      chk({p, ".busy"},  int'(bsy[s]), int'(mbusy(s)));
      chk({p, ".done"},  int'(dn[s]),  int'(mdone[s]));
      chk({p, ".count"}, int'(cnt[s]), mcnt[s]);
    end
  endtask

  task automatic tick();
    if (vld[0]) cap.push_back(int'(idx[0]));
    @(posedge clk);
    if (reset) model_step();
    else model_reset();
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((mbusy(0) || mbusy(1)) && n < 80) begin
      tick();
      n++;
    end
    chk("wait_idle_timeout", int'(mbusy(0) || mbusy(1)), 0);
  endtask

  task automatic job(logic [31:0] m);
    start = 1'b1;
    mask  = m;
    ready = 1'b1;
    tick();
    start = 1'b0;
    wait_idle();
  endtask

  vec_t vecs[8];
  int   exp4[4];
  int   expbp[5];

  initial begin
    vecs[0] = '{32'h0000_0002, 1, 1, 1};
    vecs[1] = '{32'h0000_0001, 0, 1, -1};
    vecs[2] = '{32'h8000_0026, 4, 4, 1};
    vecs[3] = '{32'hFFFF_FFFF, 31, 32, 1};
    vecs[4] = '{32'h0000_0000, 0, 0, -1};
    vecs[5] = '{32'h0000_0300, 2, 2, 8};
    vecs[6] = '{32'h8000_0000, 1, 1, 31};
    vecs[7] = '{32'h5555_5555, 15, 16, 2};
    exp4    = '{1, 2, 5, 31};
    expbp   = '{8, 8, 8, 9, 9};

    reset = 1'b0; start = 1'b0; ready = 1'b0; mask = '0;
    model_reset();
    #3;
    check_all();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) tick();

    // Table of whole jobs with Ready held high
    foreach (vecs[i]) begin
      cap.delete();
      job(vecs[i].m);
      chk("tbl.count_a", int'(cnt[0]), vecs[i].cnt_a);
      chk("tbl.count_b", int'(cnt[1]), vecs[i].cnt_b);
      chk("tbl.ncap_a", cap.size(), vecs[i].cnt_a);
      chk("tbl.first_a", (cap.size() > 0) ? cap[0] : -1, vecs[i].first_a);
    end

    // Decoder inverse
    for (int k = 1; k < 32; k++) begin
      logic [31:0] one;
      one = 32'h1 << k;
      cap.delete();
      job(one);
      chk("inv.ncap", cap.size(), 1);
      chk("inv.index", (cap.size() > 0) ? cap[0] : -1, k);
      chk("inv.count", int'(cnt[0]), 1);
    end

    // x0-only mask: A finishes straight away, B emits index 0
    start = 1'b1; mask = 32'h1; ready = 1'b1;
    tick();
    start = 1'b0;
    chk("x0.done_a", int'(dn[0]), 1);
    chk("x0.valid_a", int'(vld[0]), 0);
    chk("x0.valid_b", int'(vld[1]), 1);
    wait_idle();
    chk("x0.count_a", int'(cnt[0]), 0);

    // Ordering
    cap.delete();
    job(32'h8000_0026);
    chk("ord.n", cap.size(), 4);
    for (int i = 0; i < 4; i++) chk("ord.idx", (i < cap.size()) ? cap[i] : -1, exp4[i]);

    // Backpressure with a stray Start during EMIT
    cap.delete();
    start = 1'b1; mask = 32'h0000_0300; ready = 1'b1;
    tick();
    ready = 1'b0; start = 1'b1; mask = 32'h0000_0004; tick();
    ready = 1'b0; start = 1'b0; tick();
    ready = 1'b1; tick();
    ready = 1'b0; tick();
    ready = 1'b1; tick();
    chk("bp.done_a", int'(dn[0]), 1);
    chk("bp.n", cap.size(), 5);
    for (int i = 0; i < 5; i++) chk("bp.idx", (i < cap.size()) ? cap[i] : -1, expbp[i]);
    wait_idle();
    chk("bp.count_b", int'(cnt[1]), 2);

    // Full mask
    job(32'hFFFF_FFFF);
    chk("full.count_a", int'(cnt[0]), 31);
    chk("full.count_b", int'(cnt[1]), 32);

    // Asynchronous reset mid-job, after index 5 is accepted
    start = 1'b1; mask = 32'h0000_00F0; ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("rst.pre_idx", int'(idx[0]), 6);
    #2 reset = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("rst.valid", int'(vld[s]), 0);
      chk("rst.done", int'(dn[s]), 0);
      chk("rst.busy", int'(bsy[s]), 0);
      chk("rst.count", int'(cnt[s]), 0);
      chk("rst.index", int'(idx[s]), 0);
    end
    model_reset();
    tick();
    reset = 1'b1;
    tick();
    cap.delete();
    job(32'h0000_0004);
    chk("post.ncap", cap.size(), 1);
    chk("post.index", (cap.size() > 0) ? cap[0] : -1, 2);
    chk("post.count", int'(cnt[0]), 1);

    // Random traffic: Start only when both instances agree on being idle or busy
    for (int i = 0; i < 1500; i++) begin
      if (!mbusy(0) && !mbusy(1)) begin
        start = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
          0: mask = '0;
          1: mask = 32'h1 << $urandom_range(0, 31);
          2: mask = $urandom;
          default: mask = $urandom & $urandom & $urandom;
        endcase
      end else if (mbusy(0) && mbusy(1)) begin
        start = 1'($urandom_range(0, 1));
        mask  = $urandom;
      end else begin
        start = 1'b0;
      end
      ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    start = 1'b0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
